// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared interval/selector codes and default durations for the light controller
package tlc_pkg;

    localparam logic [1:0] T_BASE = 2'b00;
    localparam logic [1:0] T_EXT  = 2'b01;
    localparam logic [1:0] T_YEL  = 2'b10;
    localparam logic [1:0] T_BX2  = 2'b11;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;

    localparam int DEF_BASE_S = 6;
    localparam int DEF_EXT_S  = 3;
    localparam int DEF_YEL_S  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/one_hz_divider.sv
// rtl/one_hz_divider.sv - prescaler producing a one-cycle tick every CLK_FREQ_HZ enabled cycles
module one_hz_divider #(
    parameter int CLK_FREQ_HZ = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_FREQ_HZ - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == LAST);

    // clear wins so a restart always begins a full second
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/light_interval_timer.sv
// rtl/light_interval_timer.sv - programmable duration registers and 1 s countdown with expiry pulse
module light_interval_timer
    import tlc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int VALUE_W     = 4,
    parameter int DEF_BASE    = DEF_BASE_S,
    parameter int DEF_EXT     = DEF_EXT_S,
    parameter int DEF_YEL     = DEF_YEL_S
) (
    input  logic               clk,
    input  logic               Reset_n,
    input  logic               Prog_Sync,
    input  logic [1:0]         Time_Param_Selector,
    input  logic [VALUE_W-1:0] Time_Value,
    input  logic [1:0]         interval,
    input  logic               start_timer,
    output logic               expired,
    output logic               busy,
    output logic [VALUE_W:0]   secs_left
);

    localparam logic [VALUE_W-1:0] BASE_RST = VALUE_W'(DEF_BASE);
    localparam logic [VALUE_W-1:0] EXT_RST  = VALUE_W'(DEF_EXT);
    localparam logic [VALUE_W-1:0] YEL_RST  = VALUE_W'(DEF_YEL);
    localparam logic [VALUE_W:0]   ONE_SEC  = (VALUE_W+1)'(1);

    logic [VALUE_W-1:0] t_base, t_ext, t_yel;
    logic [VALUE_W:0]   start_len;
    logic               tick;

    timer_state_t       state, state_next;
    logic [VALUE_W:0]   secs_next;
    logic               busy_next, expired_next;

    // a zero value restores the default so no zero-length interval can be stored
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            t_base <= BASE_RST;
            t_ext  <= EXT_RST;
            t_yel  <= YEL_RST;
        end else if (Prog_Sync) begin
            case (Time_Param_Selector)
                SEL_BASE: t_base <= (Time_Value == '0) ? BASE_RST : Time_Value;
                SEL_EXT:  t_ext  <= (Time_Value == '0) ? EXT_RST  : Time_Value;
                SEL_YEL:  t_yel  <= (Time_Value == '0) ? YEL_RST  : Time_Value;
                default:  ;
            endcase
        end
    end

    always_comb begin
        start_len = '0;
        case (interval)
            T_BASE:  start_len = {1'b0, t_base};
            T_EXT:   start_len = {1'b0, t_ext};
            T_YEL:   start_len = {1'b0, t_yel};
            T_BX2:   start_len = {t_base, 1'b0};
            default: start_len = '0;
        endcase
    end

    one_hz_divider #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_div (
        .clk    (clk),
        .rst_n  (Reset_n),
        .clear  (start_timer),
        .enable (state == ST_RUN),
        .tick   (tick)
    );

    // start_timer outranks a same-cycle tick, so a restart never emits the aborted expiry
    always_comb begin
        state_next   = state;
        secs_next    = secs_left;
        busy_next    = busy;
        expired_next = 1'b0;
        if (start_timer) begin
            state_next = ST_RUN;
            secs_next  = start_len;
            busy_next  = 1'b1;
        end else if (state == ST_RUN && tick) begin
            if (secs_left == ONE_SEC) begin
                state_next   = ST_IDLE;
                secs_next    = '0;
                busy_next    = 1'b0;
                expired_next = 1'b1;
            end else begin
                secs_next = secs_left - ONE_SEC;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            secs_left <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_next;
            secs_left <= secs_next;
            busy      <= busy_next;
            expired   <= expired_next;
        end
    end

endmodule

// File: tb/tb_light_interval_timer.sv
// tb/tb_light_interval_timer.sv - directed self-checking bench for light_interval_timer
module tb_light_interval_timer;
    import tlc_pkg::*;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic       Prog_Sync;
    logic [1:0] Time_Param_Selector;
    logic [3:0] Time_Value;
    logic [1:0] interval;
    logic       start_timer;
    logic       expired;
    logic       busy;
    logic [4:0] secs_left;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    light_interval_timer #(
        .CLK_FREQ_HZ(4),
        .VALUE_W    (4),
        .DEF_BASE   (6),
        .DEF_EXT    (3),
        .DEF_YEL    (2)
    ) dut (
        .clk                 (clk),
        .Reset_n             (Reset_n),
        .Prog_Sync           (Prog_Sync),
        .Time_Param_Selector (Time_Param_Selector),
        .Time_Value          (Time_Value),
        .interval            (interval),
        .start_timer         (start_timer),
        .expired             (expired),
        .busy                (busy),
        .secs_left           (secs_left)
    );

    task automatic start(input logic [1:0] iv);
        start_timer = 1'b1;
        interval    = iv;
        @(posedge clk);
        #1;
        start_timer = 1'b0;
    endtask

    task automatic program_reg(input logic [1:0] sel, input logic [3:0] val);
        Prog_Sync           = 1'b1;
        Time_Param_Selector = sel;
        Time_Value          = val;
        @(posedge clk);
        #1;
        Prog_Sync = 1'b0;
    endtask

    task automatic run_window(input int limit, output int first, output int pulses, output int busy_cnt);
        first    = -1;
        pulses   = 0;
        busy_cnt = busy ? 1 : 0;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk);
            #1;
            if (expired) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Prog_Sync = 1'b0; Time_Param_Selector = 2'b00;
        Time_Value = 4'd0; interval = 2'b00; start_timer = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (expired !== 1'b0) begin bad++; $display("FAIL reset_expired: got %b want 0", expired); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (secs_left !== 5'd0) begin bad++; $display("FAIL reset_secs: got %0d want 0", secs_left); end
        #3 Reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_base();
        int first, pulses, bc;
        start(T_BASE);
        total++; if (secs_left !== 5'd6) begin bad++; $display("FAIL base_secs0: got %0d want 6", secs_left); end
        run_window(30, first, pulses, bc);
        total++; if (first !== 24) begin bad++; $display("FAIL base_latency: got %0d want 24", first); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL base_pulses: got %0d want 1", pulses); end
        total++; if (bc !== 24) begin bad++; $display("FAIL base_busy_cycles: got %0d want 24", bc); end
    endtask

    task automatic test_bx2();
        int first, pulses, bc;
        start(T_BX2);
        total++; if (secs_left !== 5'd12) begin bad++; $display("FAIL bx2_secs0: got %0d want 12", secs_left); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (secs_left !== 5'd12) begin bad++; $display("FAIL bx2_secs3: got %0d want 12", secs_left); end
        @(posedge clk);
        #1;
        total++; if (secs_left !== 5'd11) begin bad++; $display("FAIL bx2_secs4: got %0d want 11", secs_left); end
        repeat (4) @(posedge clk);
        #1;
        total++; if (secs_left !== 5'd10) begin bad++; $display("FAIL bx2_secs8: got %0d want 10", secs_left); end
        run_window(50, first, pulses, bc);
        total++; if (first !== 40) begin bad++; $display("FAIL bx2_latency: got %0d want 40", first); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL bx2_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_restart();
        int first, pulses, bc, early;
        early = 0;
        start(T_BASE);
        repeat (9) begin
            @(posedge clk);
            #1;
            if (expired) early++;
        end
        start(T_YEL);
        total++; if (secs_left !== 5'd2) begin bad++; $display("FAIL restart_secs0: got %0d want 2", secs_left); end
        run_window(30, first, pulses, bc);
        total++; if (early !== 0) begin bad++; $display("FAIL restart_early: got %0d want 0", early); end
        total++; if (first !== 8) begin bad++; $display("FAIL restart_latency: got %0d want 8", first); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL restart_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_program();
        int first, pulses, bc;
        program_reg(SEL_YEL, 4'd5);
        start(T_YEL);
        run_window(30, first, pulses, bc);
        total++; if (first !== 20) begin bad++; $display("FAIL prog_yel: got %0d want 20", first); end
        program_reg(SEL_EXT, 4'd0);
        start(T_EXT);
        run_window(20, first, pulses, bc);
        total++; if (first !== 12) begin bad++; $display("FAIL prog_ext_zero: got %0d want 12", first); end
        program_reg(2'b11, 4'd15);
        start(T_BASE);
        run_window(30, first, pulses, bc);
        total++; if (first !== 24) begin bad++; $display("FAIL prog_sel11: got %0d want 24", first); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL prog_sel11_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back();
        int first, pulses, bc;
        int found;
        found = 0;
        start(T_EXT);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (expired) begin
                found = c;
                break;
            end
        end
        total++; if (found !== 12) begin bad++; $display("FAIL b2b_first: got %0d want 12", found); end
        start(T_EXT);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
        total++; if (secs_left !== 5'd3) begin bad++; $display("FAIL b2b_secs0: got %0d want 3", secs_left); end
        run_window(20, first, pulses, bc);
        total++; if (first !== 12) begin bad++; $display("FAIL b2b_second: got %0d want 12", first); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_same_cycle();
        int first, pulses, bc;
        Prog_Sync           = 1'b1;
        Time_Param_Selector = SEL_BASE;
        Time_Value          = 4'd9;
        start(T_BX2);
        Prog_Sync = 1'b0;
        total++; if (secs_left !== 5'd12) begin bad++; $display("FAIL same_secs0: got %0d want 12", secs_left); end
        run_window(60, first, pulses, bc);
        total++; if (first !== 48) begin bad++; $display("FAIL same_latency: got %0d want 48", first); end
        start(T_BASE);
        total++; if (secs_left !== 5'd9) begin bad++; $display("FAIL same_next_secs0: got %0d want 9", secs_left); end
        run_window(45, first, pulses, bc);
        total++; if (first !== 36) begin bad++; $display("FAIL same_next_latency: got %0d want 36", first); end
    endtask

    task automatic test_reset_mid();
        int first, pulses, bc;
        start(T_BASE);
        repeat (10) @(posedge clk);
        #3 Reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        total++; if (secs_left !== 5'd0) begin bad++; $display("FAIL rstmid_secs: got %0d want 0", secs_left); end
        repeat (2) @(posedge clk);
        #3 Reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_window(60, first, pulses, bc);
        total++; if (pulses !== 0) begin bad++; $display("FAIL rstmid_no_expiry: got %0d want 0", pulses); end
        start(T_BASE);
        total++; if (secs_left !== 5'd6) begin bad++; $display("FAIL rstmid_base_default: got %0d want 6", secs_left); end
        run_window(30, first, pulses, bc);
        total++; if (first !== 24) begin bad++; $display("FAIL rstmid_latency: got %0d want 24", first); end
    endtask

    initial begin
        test_reset();
        test_base();
        test_bx2();
        test_restart();
        test_program();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
